snoop_bus_ctrl: RTL and testbench
=================================

Name: snoop_bus_ctrl

Overview:
- Shared snoop-bus controller sitting directly downstream of the per-processor MESI caches.
- Arbitrates their bus requests round-robin and broadcasts the granted operation as a snoop to all other caches.
- Collects shared/dirty responses and sequences memory reads and writes, including dirty-owner flush.
- Returns line data, data_ready and the shared indication to the granted cache.

Parameters:
- N_CACHES, 4, number of attached caches (2..8)
- ADDR_WIDTH, 32, address width
- LINE_SIZE, 32, line size in bytes; LINE_BITS = LINE_SIZE*8
- RESP_CYCLES, 2, cycles data_ready is held in RESP (the cache samples data_ready in its wait state and again in FILL)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req  in  N_CACHES  per-cache bus_req
- req_op  in  3*N_CACHES  per-cache op: 000 writeback, 001 BusRd, 010 BusRdX, 011 BusUpgr
- req_addr  in  ADDR_WIDTH*N_CACHES  per-cache address
- req_data  in  LINE_BITS*N_CACHES  per-cache line out (writeback/flush data)
- req_data_valid  in  N_CACHES  per-cache data valid
- grant  out  N_CACHES  one-hot grant
- snoop_op  out  3  broadcast snoop op (000 when idle)
- snoop_addr  out  ADDR_WIDTH  broadcast snoop address
- snoop_mask  out  N_CACHES  caches that must act on the snoop (requester bit 0)
- snoop_hit  in  N_CACHES  cache holds the line valid
- snoop_dirty  in  N_CACHES  cache holds the line in M
- bus_data  out  LINE_BITS  line data to requester
- bus_data_ready  out  1  data/completion strobe
- bus_shared  out  1  another cache holds the line
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  line-aligned memory address
- mem_wdata  out  LINE_BITS  memory write data
- mem_rdata  in  LINE_BITS  memory read data
- mem_ack  in  1  single-cycle memory completion

Behaviour:
- Reset (rst sampled high on clk edge): state IDLE; all outputs 0; round-robin pointer at 0. Reset mid-transaction aborts with no memory write.
- States: IDLE, SNOOP, FLUSH, MEM, RESP.
- IDLE: if any req, pick the first requester at or after the pointer (wrapping). Latch its id, op and addr. Assert its grant from the next cycle; go to SNOOP. The pointer becomes id+1 mod N_CACHES.
- grant stays asserted from SNOOP through the last RESP cycle. Other requests wait; req lines are level, no queueing.
- Writeback (op 000) skips snooping. SNOOP waits for the requester's req_data_valid, latches req_data, then goes to MEM with mem_we=1.
- Rd/RdX/Upgr SNOOP, 1 cycle:
  - snoop_op=latched op, snoop_addr=latched addr, snoop_mask = all ones except the requester.
  - Latch shared = |(snoop_hit & mask); latch dirty owner = lowest index in snoop_dirty & mask.
  - Upgr: go to IDLE and drop grant (the cache leaves on grant); no data_ready.
  - Otherwise, a dirty owner goes to FLUSH, else MEM with mem_we=0.
- FLUSH: wait for the owner's req_data_valid; latch its req_data as the line. Go to MEM with mem_we=1; the flushed line is forwarded to the requester with no memory read.
- MEM: mem_req held high until mem_ack; mem_addr has its low log2(LINE_SIZE) bits zeroed. A read captures mem_rdata on mem_ack. Go to RESP.
- RESP: bus_data_ready=1 and bus_data=line for RESP_CYCLES cycles.
  - bus_shared = latched shared. It is forced 0 for RdX and for writeback. It is 1 for Rd when a dirty flush occurred.
  - Then IDLE; grant drops the cycle after the last RESP cycle.
- Latency: minimum Rd miss, clean, is req -> grant +1, snoop +1, MEM ≥1 + mem latency, RESP RESP_CYCLES.
- Simultaneous req from all caches: strict rotation, no starvation. Each requester is served within N_CACHES transactions.
- snoop_op is 000 in every state except SNOOP.
- A requester dropping req after grant is ignored; the transaction completes.
- Multiple snoop_dirty set is a protocol error. The lowest index wins; a sim-only assertion flags it.

Decomposition:
- Package snoop_bus_pkg holds the op encodings (OP_WB=000, OP_RD=001, OP_RDX=010, OP_UPGR=011) and the FSM state enum/constants, shared with the cache controller.
- One sub-module rr_arbiter (N-way round-robin, one-hot grant, pointer update on accept).

Test Plan:
- Single BusRd from cache 1, addr 0x0000_1044, no hits, mem returns 0xAA..AA. Expected: grant=0010; mem_addr=0x0000_1040, mem_we=0; data_ready for 2 cycles with bus_data=0xAA..AA, bus_shared=0.
- BusRd from cache 0 with cache 2 snoop_hit. Expected: snoop_mask=1110, bus_shared=1 during RESP.
- BusRdX from cache 3 with cache 1 snoop_dirty supplying 0x55..55. Expected: FLUSH then memory write of 0x55..55; requester receives 0x55..55, bus_shared=0; no memory read issued.
- BusUpgr from cache 2. Expected: one SNOOP cycle with snoop_op=011, then grant drops; no mem_req and no data_ready.
- Writeback (op 000) from cache 0 with data 0x12..34. Expected: no snoop; mem_we=1, mem_wdata=0x12..34; data_ready pulse of 2 cycles.
- All four req high continuously. Expected: grants in order 0,1,2,3,0. Reset asserted in MEM clears mem_req and grant the next cycle.

Source files
------------

// File: rtl/snoop_bus_pkg.sv
// Bus op encodings and controller state constants shared by the snoop-bus controller and the cache controllers.
package snoop_bus_pkg;

  localparam logic [2:0] OP_WB   = 3'b000;
  localparam logic [2:0] OP_RD   = 3'b001;
  localparam logic [2:0] OP_RDX  = 3'b010;
  localparam logic [2:0] OP_UPGR = 3'b011;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SNOOP = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  function automatic logic op_snoops(input logic [2:0] op);
    return (op == OP_RD) || (op == OP_RDX) || (op == OP_UPGR);
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// N-way round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner on accept.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_req,
  input  logic           i_accept,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_id,
  output logic           o_any
);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_any = 1'b0;
    o_id  = '0;
    w_sum = '0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(N)) w_sum = w_sum - (IDW+1)'(N);
      w_idx = w_sum[IDW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any = 1'b1;
        o_id  = w_idx;
      end
    end
  end

  assign o_gnt = o_any ? (N'(1) << o_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept && o_any) begin
      r_ptr <= (o_id == IDW'(N-1)) ? '0 : o_id + 1'b1;
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snoop-bus controller: round-robin grant, snoop broadcast, dirty-owner flush, memory sequencing,
// and line return to the granted cache with data_ready held for RESP_CYCLES.
module snoop_bus_ctrl
  import snoop_bus_pkg::*;
#(
  parameter int N_CACHES    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_SIZE   = 32,
  parameter int RESP_CYCLES = 2,
  localparam int LINE_BITS  = LINE_SIZE * 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CACHES-1:0]            req,
  input  logic [3*N_CACHES-1:0]          req_op,
  input  logic [ADDR_WIDTH*N_CACHES-1:0] req_addr,
  input  logic [LINE_BITS*N_CACHES-1:0]  req_data,
  input  logic [N_CACHES-1:0]            req_data_valid,
  output logic [N_CACHES-1:0]            grant,
  output logic [2:0]                     snoop_op,
  output logic [ADDR_WIDTH-1:0]          snoop_addr,
  output logic [N_CACHES-1:0]            snoop_mask,
  input  logic [N_CACHES-1:0]            snoop_hit,
  input  logic [N_CACHES-1:0]            snoop_dirty,
  output logic [LINE_BITS-1:0]           bus_data,
  output logic                           bus_data_ready,
  output logic                           bus_shared,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [LINE_BITS-1:0]           mem_wdata,
  input  logic [LINE_BITS-1:0]           mem_rdata,
  input  logic                           mem_ack
);

  localparam int IDW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CW  = $clog2(RESP_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << $clog2(LINE_SIZE);

  logic [2:0]            r_state;
  logic [IDW-1:0]        r_id;
  logic [IDW-1:0]        r_owner;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [N_CACHES-1:0]   r_grant;
  logic [LINE_BITS-1:0]  r_line;
  logic                  r_we;
  logic                  r_shared;
  logic                  r_flushed;
  logic [CW-1:0]         r_cnt;

  logic [2:0]            w_op   [N_CACHES];
  logic [ADDR_WIDTH-1:0] w_addr [N_CACHES];
  logic [LINE_BITS-1:0]  w_data [N_CACHES];

  for (genvar g = 0; g < N_CACHES; g++) begin : g_unpack
    assign w_op[g]   = req_op[3*g +: 3];
    assign w_addr[g] = req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
    assign w_data[g] = req_data[LINE_BITS*g +: LINE_BITS];
  end

  logic [N_CACHES-1:0] w_arb_gnt;
  logic [IDW-1:0]      w_arb_id;
  logic                w_arb_any;
  logic                w_accept;

  assign w_accept = (r_state == ST_IDLE);

  rr_arbiter #(.N(N_CACHES), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_accept (w_accept),
    .o_gnt    (w_arb_gnt),
    .o_id     (w_arb_id),
    .o_any    (w_arb_any)
  );

  // The granted requester never acts on its own snoop.
  logic [N_CACHES-1:0] w_mask;
  logic [N_CACHES-1:0] w_dirty;
  logic [IDW-1:0]      w_owner;

  assign w_mask  = ~r_grant;
  assign w_dirty = snoop_dirty & w_mask;

  always_comb begin
    w_owner = '0;
    for (int i = N_CACHES - 1; i >= 0; i--) begin
      if (w_dirty[i]) w_owner = IDW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_id      <= '0;
      r_owner   <= '0;
      r_op      <= OP_WB;
      r_addr    <= '0;
      r_grant   <= '0;
      r_line    <= '0;
      r_we      <= 1'b0;
      r_shared  <= 1'b0;
      r_flushed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_id      <= w_arb_id;
            r_op      <= w_op[w_arb_id];
            r_addr    <= w_addr[w_arb_id];
            r_grant   <= w_arb_gnt;
            r_we      <= 1'b0;
            r_shared  <= 1'b0;
            r_flushed <= 1'b0;
            r_state   <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          if (!op_snoops(r_op)) begin
            if (req_data_valid[r_id]) begin
              r_line  <= w_data[r_id];
              r_we    <= 1'b1;
              r_state <= ST_MEM;
            end
          end else begin
            r_shared <= |(snoop_hit & w_mask);
            r_owner  <= w_owner;
            if (r_op == OP_UPGR) begin
              r_grant <= '0;
              r_state <= ST_IDLE;
            end else if (|w_dirty) begin
              r_state <= ST_FLUSH;
            end else begin
              r_we    <= 1'b0;
              r_state <= ST_MEM;
            end
          end
        end
        ST_FLUSH: begin
          if (req_data_valid[r_owner]) begin
            r_line    <= w_data[r_owner];
            r_we      <= 1'b1;
            r_flushed <= 1'b1;
            r_state   <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (!r_we) r_line <= mem_rdata;
            r_cnt   <= CW'(RESP_CYCLES - 1);
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (r_cnt == '0) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant          = r_grant;
  assign snoop_op       = (r_state == ST_SNOOP) ? r_op : OP_WB;
  assign snoop_addr     = (r_state == ST_SNOOP) ? r_addr : '0;
  assign snoop_mask     = (r_state == ST_SNOOP && op_snoops(r_op)) ? w_mask : '0;
  assign bus_data_ready = (r_state == ST_RESP);
  assign bus_data       = (r_state == ST_RESP) ? r_line : '0;
  // A flushed line was dirty in another cache, so a plain read must not install it exclusive.
  assign bus_shared     = (r_state == ST_RESP) && (r_op == OP_RD) && (r_shared || r_flushed);
  assign mem_req        = (r_state == ST_MEM);
  assign mem_we         = (r_state == ST_MEM) && r_we;
  assign mem_addr       = (r_state == ST_MEM) ? (r_addr & ALIGN_MASK) : '0;
  assign mem_wdata      = (r_state == ST_MEM && r_we) ? r_line : '0;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && r_state == ST_SNOOP && op_snoops(r_op)) begin
      assert ($onehot0(w_dirty));
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Bench for snoop_bus_ctrl: directed transactions plus randomized ones checked against a transaction-level model.
module tb_snoop_bus_ctrl;
  import snoop_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LB = 256;
  localparam int RC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [3*N-1:0]  req_op;
  logic [AW*N-1:0] req_addr;
  logic [LB*N-1:0] req_data;
  logic [N-1:0]    req_data_valid;
  logic [N-1:0]    grant;
  logic [2:0]      snoop_op;
  logic [AW-1:0]   snoop_addr;
  logic [N-1:0]    snoop_mask;
  logic [N-1:0]    snoop_hit;
  logic [N-1:0]    snoop_dirty;
  logic [LB-1:0]   bus_data;
  logic            bus_data_ready;
  logic            bus_shared;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [LB-1:0]   mem_wdata;
  logic [LB-1:0]   mem_rdata;
  logic            mem_ack = 1'b0;

  logic [LB-1:0]   cdata [N];
  logic [LB-1:0]   m_rdata;
  int              m_lat = 1;
  int              mc = 0;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[g*LB +: LB] = cdata[g];
  end
  assign mem_rdata = m_rdata;

  snoop_bus_ctrl #(.N_CACHES(N), .ADDR_WIDTH(AW), .LINE_SIZE(32), .RESP_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .req_data_valid(req_data_valid), .grant(grant),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_mask(snoop_mask),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .bus_data(bus_data),
    .bus_data_ready(bus_data_ready), .bus_shared(bus_shared), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory: acknowledges a request after m_lat cycles with a one-cycle pulse.
  always @(negedge clk) begin
    if (mem_req && !mem_ack) begin
      mc = mc + 1;
      if (mc >= m_lat) mem_ack = 1'b1;
    end else begin
      mem_ack = 1'b0;
      mc = 0;
    end
  end

  int            o_gid, o_glat, o_gdrop, o_gbad, o_snoop_cyc, o_xfers, o_memreq_cyc, o_dr, o_last_dr, o_spur;
  bit            o_timeout;
  logic          o_we, o_shared;
  logic [2:0]    o_snoop_op;
  logic [N-1:0]  o_mask, o_gval;
  logic [AW-1:0] o_maddr, o_saddr;
  logic [LB-1:0] o_wdata, o_bdata;

  // Drives one transaction from a single requester and records what the bus did.
  task automatic run_txn(input int id, input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [N-1:0] hit, input logic [N-1:0] dirty, input int dly);
    int gcyc;
    bit seen, done;
    logic [N-1:0] wbv;
    seen = 0; done = 0; gcyc = 0;
    o_gid = -1; o_glat = 0; o_gdrop = 0; o_gbad = 0; o_snoop_cyc = 0; o_xfers = 0;
    o_memreq_cyc = 0; o_dr = 0; o_last_dr = 0; o_spur = 0;
    o_we = 0; o_shared = 0; o_snoop_op = '0; o_mask = '0; o_gval = '0;
    o_maddr = '0; o_saddr = '0; o_wdata = '0; o_bdata = '0;
    wbv = (op == OP_WB) ? (N'(1) << id) : '0;
    req_op[3*id +: 3] = op;
    req_addr[AW*id +: AW] = addr;
    snoop_hit = hit;
    snoop_dirty = dirty;
    req[id] = 1'b1;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk); #1;
      if (!seen && grant != '0) begin
        seen = 1; gcyc = cyc; o_glat = cyc; o_gval = grant; req[id] = 1'b0;
        for (int i = 0; i < N; i++) if (grant[i]) o_gid = i;
      end else if (seen && grant == '0) begin
        done = 1; o_gdrop = cyc;
      end
      if (grant != '0 && grant != o_gval) o_gbad++;
      if (snoop_op != 3'b000 || snoop_mask != '0) begin
        o_snoop_cyc++; o_snoop_op = snoop_op; o_mask = snoop_mask; o_saddr = snoop_addr;
      end
      if (mem_req) o_memreq_cyc++;
      if (mem_req && mem_ack) begin
        o_xfers++; o_we = mem_we; o_maddr = mem_addr; o_wdata = mem_wdata;
      end
      if (bus_data_ready) begin
        o_dr++; o_bdata = bus_data; o_shared = bus_shared; o_last_dr = cyc;
      end else if (bus_shared || bus_data != '0) begin
        o_spur++;
      end
      if (seen && cyc - gcyc >= dly) req_data_valid = dirty | wbv;
    end
    req = '0; req_data_valid = '0; snoop_hit = '0; snoop_dirty = '0;
    o_timeout = !done;
  endtask

  // Transaction-level expectation from the protocol rules.
  task automatic model_txn(input int id, input logic [2:0] op, input logic [N-1:0] hit,
                           input logic [N-1:0] dirty, output int e_snoop, output logic [N-1:0] e_mask,
                           output int e_xfers, output logic e_we, output logic [LB-1:0] e_line,
                           output int e_dr, output logic e_shared);
    logic [N-1:0] others;
    int owner;
    others = ~(N'(1) << id);
    owner = -1;
    for (int i = N - 1; i >= 0; i--) if (dirty[i] && others[i]) owner = i;
    e_snoop = (op == OP_WB) ? 0 : 1;
    e_mask = others;
    e_xfers = (op == OP_UPGR) ? 0 : 1;
    e_dr = (op == OP_UPGR) ? 0 : RC;
    e_we = 1'b0; e_line = m_rdata; e_shared = 1'b0;
    if (op == OP_WB) begin
      e_we = 1'b1; e_line = cdata[id];
    end else if (op != OP_UPGR && owner >= 0) begin
      e_we = 1'b1; e_line = cdata[owner]; e_shared = (op == OP_RD);
    end else if (op == OP_RD) begin
      e_shared = |(hit & others);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (grant !== '0 || snoop_op !== 3'b000 || snoop_mask !== '0 || snoop_addr !== '0 || mem_req !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || bus_data_ready !== 1'b0 ||
        bus_data !== '0 || bus_shared !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: grant=%b snoop_op=%b mem_req=%b dr=%b, all must be 0", grant, snoop_op, mem_req, bus_data_ready);
    end
    req = '0; rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL idle_no_req: grant=%b want 0", grant); end
  endtask

  task automatic test_rd_miss();
    m_rdata = {32{8'hAA}}; m_lat = 2;
    run_txn(1, OP_RD, 32'h0000_1044, '0, '0, 0);
    checks++;
    if (o_timeout || o_gval !== 4'b0010) begin errors++; $display("FAIL rd_miss_grant: got %b want 0010 (timeout %0d)", o_gval, o_timeout); end
    checks++;
    if (o_xfers !== 1 || o_we !== 1'b0 || o_maddr !== 32'h0000_1040) begin
      errors++; $display("FAIL rd_miss_mem: xfers=%0d we=%b addr=%h want 1/0/00001040", o_xfers, o_we, o_maddr);
    end
    checks++;
    if (o_dr !== 2 || o_bdata !== {32{8'hAA}} || o_shared !== 1'b0) begin
      errors++; $display("FAIL rd_miss_resp: dr=%0d data=%h shared=%b want 2/aa..aa/0", o_dr, o_bdata, o_shared);
    end
  endtask

  task automatic test_rd_shared();
    m_rdata = {8{32'h0BAD_F00D}}; m_lat = 1;
    run_txn(0, OP_RD, 32'h0000_2000, 4'b0100, '0, 0);
    checks++;
    if (o_timeout || o_mask !== 4'b1110) begin errors++; $display("FAIL rd_shared_mask: got %b want 1110", o_mask); end
    checks++;
    if (o_dr !== 2 || o_shared !== 1'b1 || o_bdata !== m_rdata) begin
      errors++; $display("FAIL rd_shared_resp: dr=%0d shared=%b data=%h want 2/1/%h", o_dr, o_shared, o_bdata, m_rdata);
    end
  endtask

  task automatic test_rdx_flush();
    cdata[1] = {32{8'h55}}; m_rdata = {32{8'hC3}}; m_lat = 1;
    run_txn(3, OP_RDX, 32'h0000_3000, 4'b0010, 4'b0010, 2);
    checks++;
    if (o_timeout || o_snoop_op !== OP_RDX || o_mask !== 4'b0111) begin
      errors++; $display("FAIL rdx_snoop: op=%b mask=%b want 010/0111", o_snoop_op, o_mask);
    end
    checks++;
    if (o_xfers !== 1 || o_we !== 1'b1 || o_wdata !== {32{8'h55}}) begin
      errors++; $display("FAIL rdx_flush_write: xfers=%0d we=%b wdata=%h want 1 write of 55..55", o_xfers, o_we, o_wdata);
    end
    checks++;
    if (o_dr !== 2 || o_bdata !== {32{8'h55}} || o_shared !== 1'b0) begin
      errors++; $display("FAIL rdx_resp: dr=%0d data=%h shared=%b want 2/55..55/0", o_dr, o_bdata, o_shared);
    end
  endtask

  task automatic test_upgr();
    run_txn(2, OP_UPGR, 32'h0000_4000, 4'b0001, '0, 0);
    checks++;
    if (o_timeout || o_snoop_cyc !== 1 || o_snoop_op !== 3'b011) begin
      errors++; $display("FAIL upgr_snoop: cycles=%0d op=%b want 1/011", o_snoop_cyc, o_snoop_op);
    end
    checks++;
    if (o_memreq_cyc !== 0 || o_dr !== 0) begin errors++; $display("FAIL upgr_no_mem: memreq=%0d dr=%0d want 0/0", o_memreq_cyc, o_dr); end
    checks++;
    if (o_gdrop !== 2) begin errors++; $display("FAIL upgr_grant_drop: dropped at %0d want 2", o_gdrop); end
  endtask

  task automatic test_writeback();
    cdata[0] = {16{16'h1234}}; m_lat = 2;
    run_txn(0, OP_WB, 32'h0000_5008, 4'b1111, '0, 3);
    checks++;
    if (o_timeout || o_snoop_cyc !== 0) begin errors++; $display("FAIL wb_no_snoop: snoop cycles=%0d want 0", o_snoop_cyc); end
    checks++;
    if (o_xfers !== 1 || o_we !== 1'b1 || o_wdata !== {16{16'h1234}} || o_maddr !== 32'h0000_5000) begin
      errors++; $display("FAIL wb_mem: xfers=%0d we=%b addr=%h wdata=%h", o_xfers, o_we, o_maddr, o_wdata);
    end
    checks++;
    if (o_dr !== 2 || o_shared !== 1'b0) begin errors++; $display("FAIL wb_resp: dr=%0d shared=%b want 2/0", o_dr, o_shared); end
  endtask

  task automatic test_random();
    int id, dly, e_snoop, e_xfers, e_dr, ow;
    logic [2:0] op;
    logic [AW-1:0] addr;
    logic [N-1:0] hit, dirty, e_mask;
    logic e_we, e_shared;
    logic [LB-1:0] e_line;
    for (int t = 0; t < 30; t++) begin
      id = $urandom_range(0, N-1);
      op = 3'($urandom_range(0, 3));
      addr = $urandom;
      hit = N'($urandom);
      dirty = '0;
      if ($urandom_range(0, 1) == 1) begin
        ow = $urandom_range(0, N-1);
        if (ow != id) dirty[ow] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) dirty[id] = 1'b1;
      for (int i = 0; i < N; i++) for (int w = 0; w < 8; w++) cdata[i][32*w +: 32] = $urandom;
      for (int w = 0; w < 8; w++) m_rdata[32*w +: 32] = $urandom;
      m_lat = $urandom_range(1, 4);
      dly = $urandom_range(0, 3);
      model_txn(id, op, hit, dirty, e_snoop, e_mask, e_xfers, e_we, e_line, e_dr, e_shared);
      run_txn(id, op, addr, hit, dirty, dly);
      checks++;
      if (o_timeout || o_gval !== (N'(1) << id) || o_glat !== 1) begin
        errors++; $display("FAIL rand%0d grant: got %b lat %0d want %b lat 1 (timeout %0d)", t, o_gval, o_glat, N'(1) << id, o_timeout);
      end
      checks++;
      if (o_snoop_cyc !== e_snoop) begin errors++; $display("FAIL rand%0d snoop_cycles: got %0d want %0d", t, o_snoop_cyc, e_snoop); end
      if (e_snoop == 1) begin
        checks++;
        if (o_snoop_op !== op || o_mask !== e_mask || o_saddr !== addr) begin
          errors++; $display("FAIL rand%0d snoop: op=%b mask=%b addr=%h want %b/%b/%h", t, o_snoop_op, o_mask, o_saddr, op, e_mask, addr);
        end
      end
      checks++;
      if (o_xfers !== e_xfers || o_memreq_cyc !== e_xfers * m_lat) begin
        errors++; $display("FAIL rand%0d mem_count: xfers=%0d reqcyc=%0d want %0d/%0d", t, o_xfers, o_memreq_cyc, e_xfers, e_xfers * m_lat);
      end
      if (e_xfers == 1) begin
        checks++;
        if (o_we !== e_we || o_maddr !== (addr & ~32'h1F) || (e_we && o_wdata !== e_line)) begin
          errors++; $display("FAIL rand%0d mem: we=%b addr=%h wdata=%h want %b/%h/%h", t, o_we, o_maddr, o_wdata, e_we, addr & ~32'h1F, e_line);
        end
      end
      checks++;
      if (o_dr !== e_dr) begin errors++; $display("FAIL rand%0d data_ready_cycles: got %0d want %0d", t, o_dr, e_dr); end
      if (e_dr > 0) begin
        checks++;
        if (o_bdata !== e_line || o_shared !== e_shared) begin
          errors++; $display("FAIL rand%0d resp: data=%h shared=%b want %h/%b", t, o_bdata, o_shared, e_line, e_shared);
        end
        checks++;
        if (o_gdrop !== o_last_dr + 1) begin errors++; $display("FAIL rand%0d grant_drop: at %0d want %0d", t, o_gdrop, o_last_dr + 1); end
      end else begin
        checks++;
        if (o_gdrop !== o_glat + 1) begin errors++; $display("FAIL rand%0d upgr_drop: at %0d want %0d", t, o_gdrop, o_glat + 1); end
      end
      checks++;
      if (o_spur !== 0 || o_gbad !== 0) begin errors++; $display("FAIL rand%0d glitches: stray bus=%0d bad grant=%0d want 0/0", t, o_spur, o_gbad); end
    end
  endtask

  task automatic test_rotation();
    int k, cyc;
    logic [N-1:0] prev;
    rst = 1'b1; @(negedge clk); #1; rst = 1'b0;
    m_lat = 3;
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3] = OP_RD;
      req_addr[AW*i +: AW] = 32'h0000_8000 + 32'(i * 64);
    end
    snoop_hit = '0; snoop_dirty = '0;
    req = '1;
    k = 0; cyc = 0; prev = '0;
    while (k < 5 && cyc < 400) begin
      @(negedge clk); #1; cyc++;
      if (grant != '0 && prev == '0) begin
        checks++;
        if (grant !== (N'(1) << (k % N))) begin errors++; $display("FAIL rotation_%0d: grant=%b want %b", k, grant, N'(1) << (k % N)); end
        k++;
      end
      prev = grant;
    end
    if (k < 5) begin checks++; errors++; $display("FAIL rotation_timeout: saw %0d grants want 5", k); end
    cyc = 0;
    while (!mem_req && cyc < 50) begin @(negedge clk); #1; cyc++; end
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rotation_reach_mem: mem_req=%b want 1", mem_req); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || grant !== '0 || bus_data_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_mem: mem_req=%b grant=%b dr=%b want 0/0/0", mem_req, grant, bus_data_ready);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL restart_pointer: grant=%b want 0001", grant); end
    req = '0; rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_addr = '0; req_data_valid = '0;
    snoop_hit = '0; snoop_dirty = '0; m_rdata = '0;
    for (int i = 0; i < N; i++) cdata[i] = '0;
    test_reset();
    test_rd_miss();
    test_rd_shared();
    test_rdx_flush();
    test_upgr();
    test_writeback();
    test_random();
    test_rotation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
